// File: rtl/ex_alu_stage.sv
// Execute stage: ALU over two operands, result registered into the EX/MEM slot.
// Latency 1 cycle; STALL holds the slot, FLUSH kills it, reset clears everything.
module ex_alu_stage #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    input  logic [3:0]       ALU_OP,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic [4:0]       RD_IN,
    input  logic             REG_WRITE,
    input  logic             STALL,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] RESULT,
    output logic             EQUAL,
    output logic [4:0]       RD_OUT,
    output logic             REG_WRITE_OUT,
    output logic             BAD_OP
);

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRA  = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    logic [WIDTH-1:0] result_d, result_q;
    logic             bad_d;
    logic             equal_d, equal_q;
    logic             valid_q;
    logic [4:0]       rd_q;
    logic             reg_write_q;
    logic             bad_q;
    logic [4:0]       shamt;

    assign shamt   = OP_B[4:0];
    assign equal_d = (OP_A == OP_B);

    always_comb begin
        result_d = '0;
        bad_d    = 1'b0;
        case (ALU_OP)
            OP_SLL:  result_d = OP_A << shamt;
            OP_SRA:  result_d = $unsigned($signed(OP_A) >>> shamt);
            OP_SRL:  result_d = OP_A >> shamt;
            OP_ADD:  result_d = OP_A + OP_B;
            OP_SUB:  result_d = OP_A - OP_B;
            OP_AND:  result_d = OP_A & OP_B;
            OP_OR:   result_d = OP_A | OP_B;
            OP_XOR:  result_d = OP_A ^ OP_B;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(OP_A) < $signed(OP_B))};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (OP_A < OP_B)};
            default: bad_d    = 1'b1;
        endcase
    end

    // Flush only kills the control bits; the datapath registers keep their last value.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            equal_q     <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            bad_q       <= 1'b0;
        end else if (FLUSH) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            bad_q       <= 1'b0;
        end else if (!STALL) begin
            valid_q     <= IN_VALID;
            result_q    <= result_d;
            equal_q     <= equal_d;
            rd_q        <= RD_IN;
            reg_write_q <= REG_WRITE & IN_VALID;
            bad_q       <= bad_d & IN_VALID;
        end
    end

    assign OUT_VALID     = valid_q;
    assign RESULT        = result_q;
    assign EQUAL         = equal_q;
    assign RD_OUT        = rd_q;
    assign REG_WRITE_OUT = reg_write_q;
    assign BAD_OP        = bad_q;

endmodule

// File: doc/ex_alu_stage.md
EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 The block SHALL have port CLK  input  1  system clock, all state updates on rising edge.
REQ-003 The block SHALL have port RST_N  input  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-004 The block SHALL have port IN_VALID  input  1  an instruction is presented this cycle.
REQ-005 The block SHALL have port ALU_OP  input  4  operation code from the ALU controller.
REQ-006 The block SHALL have port OP_A  input  WIDTH  first operand (rs1 / forwarded value).
REQ-007 The block SHALL have port OP_B  input  WIDTH  second operand (rs2 / immediate / CSR mask).
REQ-008 The block SHALL have port RD_IN  input  5  destination register index.
REQ-009 The block SHALL have port REG_WRITE  input  1  instruction writes RD_IN.
REQ-010 The block SHALL have port STALL  input  1  downstream hold request.
REQ-011 The block SHALL have port FLUSH  input  1  kill request from the branch or interrupt unit.
REQ-012 The block SHALL have port OUT_VALID  output  1  EX/MEM slot holds a live instruction.
REQ-013 The block SHALL have port RESULT  output  WIDTH  registered ALU result.
REQ-014 The block SHALL have port EQUAL  output  1  registered OP_A == OP_B.
REQ-015 The block SHALL have port RD_OUT  output  5  registered destination index.
REQ-016 The block SHALL have port REG_WRITE_OUT  output  1  registered write enable.
REQ-017 The block SHALL have port BAD_OP  output  1  registered flag for an unsupported ALU_OP.

Function
REQ-018 The ALU_OP decode SHALL be: 0 SLL, 1 SRA, 2 SRL, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 11 SLT, 12 SLTU.
REQ-019 Codes 3, 4, 10 and 13-15 SHALL produce result 0 with BAD_OP=1; all other codes SHALL give BAD_OP=0.
REQ-020 Shift amount SHALL be OP_B[4:0]; SRA SHALL sign-fill from OP_A[WIDTH-1]; SLL/SRL SHALL zero-fill.
REQ-021 ADD and SUB SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-022 SLT (signed) and SLTU (unsigned) SHALL produce 1 or 0, zero-extended to WIDTH.
REQ-023 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-024 Load condition: RST_N=1, FLUSH=0, STALL=0 -> OUT_VALID<=IN_VALID, REG_WRITE_OUT<=REG_WRITE&IN_VALID, BAD_OP<=bad&IN_VALID, RESULT/EQUAL/RD_OUT loaded unconditionally.
REQ-025 STALL=1 with FLUSH=0 SHALL hold every output register unchanged and SHALL ignore the inputs.
REQ-026 FLUSH=1 SHALL clear OUT_VALID, REG_WRITE_OUT and BAD_OP on the next edge regardless of STALL, and RESULT/EQUAL/RD_OUT SHALL hold.
REQ-027 Priority SHALL be RST_N low > FLUSH > STALL > load.
REQ-028 IN_VALID=0 with no stall or flush SHALL insert a bubble: OUT_VALID=0, REG_WRITE_OUT=0.
REQ-029 Outputs SHALL depend only on registers, with no combinational path from any input to any output.

Reset
REQ-030 RST_N=0 at a CLK edge SHALL set OUT_VALID, RESULT, EQUAL, RD_OUT, REG_WRITE_OUT and BAD_OP to 0, overriding STALL and FLUSH.
REQ-031 Reset asserted while an instruction is held by STALL SHALL discard that instruction.
REQ-032 The first edge with RST_N=1 SHALL perform a normal load per REQ-024.

Verification
REQ-033 ADD/SUB wrap: ALU_OP=5, A=0xFFFFFFFF, B=1 -> RESULT=0, EQUAL=0 next cycle; ALU_OP=6, A=0, B=1 -> RESULT=0xFFFFFFFF.
REQ-034 Shifts and compares: SRA A=0x80000000, B=0x24 (shamt 4) -> 0xF8000000; SRL same -> 0x08000000; SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same -> 0.
REQ-035 Stall: load ADD 2+3, RD_IN=5, then STALL=1 for 3 cycles with changing inputs -> RESULT=5, RD_OUT=5, OUT_VALID=1 held throughout.
REQ-036 Flush+stall together on a valid slot -> next cycle OUT_VALID=0, REG_WRITE_OUT=0, RESULT unchanged.
REQ-037 Bad op: ALU_OP=13, IN_VALID=1 -> RESULT=0, BAD_OP=1; same with IN_VALID=0 -> BAD_OP=0.
REQ-038 Reset during stall: RST_N=0 for one edge while STALL=1 -> all outputs 0.
